inv_add_round_key_stage: RTL
============================

Name: inv_add_round_key_stage

Overview:
- Registered AddRoundKey stage of the AES-128 inverse-cipher datapath. It sits directly upstream of the InvMixColumns stage.
- Holds all 11 round keys in a local key store. It XORs each incoming 128-bit state with the round key selected by the state's round index.
- Output carries a mix flag telling downstream whether the result goes through InvMixColumns (rounds 9..1) or bypasses it (round 10 initial add, round 0 final add).
- Valid/ready handshake on both sides, one-cycle latency.

Parameters:
- NR, 10, number of AES rounds; key store depth is NR+1.
- RW, 4, round-index width; must satisfy 2^RW > NR.

Ports:
- clk  input  1  rising-edge clock, the single clock domain
- rst  input  1  synchronous, active-high reset
- key_wr_en  input  1  write one round key this cycle
- key_wr_idx  input  RW  round key index 0..NR to write
- key_wr_data  input  128  round key, byte 0 in [127:120]
- s_valid  input  1  input state valid
- s_ready  output  1  stage can accept input
- s_data  input  128  input state, byte 0 in [127:120], column-major as consumed by InvMixColumns
- s_round  input  RW  round key index to apply
- m_valid  output  1  output state valid
- m_ready  input  1  downstream accepts
- m_data  output  128  s_data XOR rk[s_round]
- m_round  output  RW  registered copy of s_round
- m_mix  output  1  1 iff 1 <= m_round <= NR-1
- m_err  output  1  index invalid or key not loaded
- keys_loaded  output  1  all NR+1 key-valid bits set

Behaviour:
- Reset (rst=1 at a clk edge): m_valid=0, m_data=0, m_round=0, m_mix=0, m_err=0, all key-valid bits cleared so keys_loaded=0. Key contents are not cleared. s_ready is forced 0 while rst=1. Any in-flight transfer is discarded.
- s_ready = ~rst & (~m_valid | m_ready), combinational. Full throughput, no bubble, when m_ready is held high.
- Accept occurs when s_valid & s_ready. On the next edge:
  - m_valid=1
  - m_data = s_data ^ rk[s_round]
  - m_round = s_round
  - m_mix and m_err computed from s_round
- Hold: while m_valid & ~m_ready, every m_* output is frozen and no input is accepted.
- Drain: m_ready & ~(s_valid & s_ready) clears m_valid on the next edge. m_data keeps its last value.
- Latency: exactly 1 cycle from accept to m_valid.
- Error conditions:
  - s_round > NR: m_err=1, m_data = s_data unmodified, m_mix=0.
  - Key-valid bit for s_round is clear: m_err=1, XOR still performed with the stored contents.
  - In both cases the data still flows through the handshake; it is never dropped.
- Key writes:
  - key_wr_en with key_wr_idx <= NR writes the key and sets its valid bit on the edge.
  - key_wr_idx > NR is ignored.
  - Writes are allowed at any time, independent of the handshake.
- Write and accept on the same index in the same cycle: the key read uses the pre-write value (read-before-write), and m_err uses the pre-write valid bit.
- Held output: an output already registered is unaffected by later key writes.
- keys_loaded is registered; it rises the cycle after the last missing key is written.

Decomposition:
- Package aes_dec_pkg holds:
  - NR = 10
  - state width 128
  - round-index width 4
  - a state typedef (128-bit) and a round-index typedef
  - a function is_mix_round(idx)
- One sub-module, aes_round_key_store:
  - 11x128 register array plus valid bitmap
  - one write port and one combinational read port (key and valid bit)
  - keys_loaded output
- The top holds the handshake register slice, XOR and flag logic.

Test Plan:
- FIPS-197 C.1 vector: write rk[10]=13111d7fe3944a17f307a78b4d2b30c5, then s_data=69c4e0d86a7b0430d8cdb78070b4c55a, s_round=10, m_ready=1 -> next cycle m_valid=1, m_data=7ad5fda789ef4e272bca100b3d9ff59f, m_mix=0, m_err=0.
- Load all 11 keys (rk[i] = {16{8'(i)}}) -> keys_loaded=1 one cycle after the 11th write. Stream s_data=0 for rounds 10..0 back-to-back -> 11 consecutive outputs with m_data = rk[i], m_mix=1 exactly for rounds 9..1, s_ready never drops.
- Backpressure: hold m_ready=0 for 5 cycles with s_valid=1 -> s_ready=0, outputs frozen. Release -> no data lost or duplicated, order preserved.
- Error paths: with rk[3] never written, send s_round=3 -> m_err=1. Send s_round=12 with s_data=A5A5...A5 -> m_err=1, m_data=A5A5...A5, m_mix=0.
- Same-cycle collision: rk[5]=0, then write rk[5]=FF..FF in the same cycle as accepting s_round=5, s_data=0 -> m_data=0. The next accept on round 5 gives FF..FF.
- Reset mid-stream: assert rst while m_valid=1 -> next cycle m_valid=0, m_data=0, keys_loaded=0, s_ready=0 during rst. The first post-reset round-0 input gives m_err=1.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared constants, types and helpers for the AES-128 inverse-cipher datapath.
package aes_dec_pkg;

    localparam int unsigned AES_NR  = 10;
    localparam int unsigned STATE_W = 128;
    localparam int unsigned ROUND_W = 4;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [ROUND_W-1:0] round_t;

    // Rounds 1..nr-1 feed InvMixColumns; the initial and final key adds bypass it.
    function automatic logic is_mix_round(input int unsigned idx, input int unsigned nr = AES_NR);
        return (idx >= 1) && (idx < nr);
    endfunction

endpackage

// File: rtl/aes_round_key_store.sv
// Local store for the NR+1 round keys with per-key valid bits.
module aes_round_key_store
    import aes_dec_pkg::*;
#(
    parameter int unsigned NR = AES_NR,
    parameter int unsigned RW = ROUND_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [RW-1:0]      wr_idx,
    input  logic [STATE_W-1:0] wr_data,
    input  logic [RW-1:0]      rd_idx,
    output logic [STATE_W-1:0] rd_key,
    output logic               rd_valid,
    output logic               keys_loaded
);

    localparam int unsigned DEPTH = NR + 1;

    state_t           keys [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_next;

    // Key contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_idx == RW'(i))) begin
                keys[i] <= wr_data;
            end
        end
    end

    // Valid bitmap after this cycle's write; out-of-range indices match nothing.
    always_comb begin
        valid_next = valid;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wr_en && (wr_idx == RW'(i))) begin
                valid_next[i] = 1'b1;
            end
        end
    end

    // Valid bits and the registered all-loaded flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid       <= '0;
            keys_loaded <= 1'b0;
        end else begin
            valid       <= valid_next;
            keys_loaded <= &valid_next;
        end
    end

    // Combinational read of current (pre-write) contents; invalid index reads as zero/invalid.
    always_comb begin
        rd_key   = '0;
        rd_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rd_idx == RW'(i)) begin
                rd_key   = keys[i];
                rd_valid = valid[i];
            end
        end
    end

endmodule

// File: rtl/inv_add_round_key_stage.sv
// Registered AddRoundKey stage of the AES-128 inverse cipher, upstream of InvMixColumns.
module inv_add_round_key_stage
    import aes_dec_pkg::*;
#(
    parameter int unsigned NR = AES_NR,
    parameter int unsigned RW = ROUND_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_wr_en,
    input  logic [RW-1:0] key_wr_idx,
    input  logic [127:0]  key_wr_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [127:0]  s_data,
    input  logic [RW-1:0] s_round,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [127:0]  m_data,
    output logic [RW-1:0] m_round,
    output logic          m_mix,
    output logic          m_err,
    output logic          keys_loaded
);

    state_t key;
    logic   key_valid;
    logic   accept;
    logic   round_ok;

    aes_round_key_store #(
        .NR (NR),
        .RW (RW)
    ) u_key_store (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (key_wr_en),
        .wr_idx      (key_wr_idx),
        .wr_data     (key_wr_data),
        .rd_idx      (s_round),
        .rd_key      (key),
        .rd_valid    (key_valid),
        .keys_loaded (keys_loaded)
    );

    assign s_ready  = ~rst & (~m_valid | m_ready);
    assign accept   = s_valid & s_ready;
    assign round_ok = (s_round <= RW'(NR));

    // Output register slice: load on accept, drop valid on drain, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_round <= '0;
            m_mix   <= 1'b0;
            m_err   <= 1'b0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= round_ok ? (s_data ^ key) : s_data;
            m_round <= s_round;
            m_mix   <= round_ok & is_mix_round(32'(s_round), NR);
            m_err   <= ~round_ok | ~key_valid;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
